// File: rtl/fifo_param.sv
// fifo_param: single-clock FIFO with occupancy count, threshold status flags
// and a sticky overflow/underflow error bit.
// Build option: define FIFO_FWFT_EN for first-word-fall-through output mode;
// otherwise popped words appear one cycle after the accepted read.
module fifo_param #(
  parameter int DATA_SIZE = 12,
  parameter int ADDR_SIZE = 3
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 write,
  input  logic                 read,
  input  logic [DATA_SIZE-1:0] data_in,
  input  logic [ADDR_SIZE:0]   th_almost_full,
  input  logic [ADDR_SIZE:0]   th_almost_empty,
  input  logic                 err_clear,
  output logic [DATA_SIZE-1:0] fifo_data_out,
  output logic                 valid,
  output logic [ADDR_SIZE:0]   count,
  output logic                 fifo_empty,
  output logic                 fifo_full,
  output logic                 almost_empty,
  output logic                 almost_full,
  output logic                 fifo_error
);

  localparam int                 DEPTH     = 2**ADDR_SIZE;
  localparam logic [ADDR_SIZE:0] DEPTH_CNT = (ADDR_SIZE+1)'(DEPTH);
  localparam logic [ADDR_SIZE:0] CNT_ONE   = (ADDR_SIZE+1)'(1);
  localparam logic [ADDR_SIZE-1:0] PTR_ONE = ADDR_SIZE'(1);

  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [ADDR_SIZE-1:0] wr_ptr;
  logic [ADDR_SIZE-1:0] rd_ptr;
  logic                 rd_acc;
  logic                 wr_acc;
  logic                 overflow;
  logic                 underflow;

  // Status flags follow count and the live thresholds; acceptance decoded from flags
  always_comb begin
    fifo_empty   = (count == '0);
    fifo_full    = (count == DEPTH_CNT);
    almost_full  = (count >= th_almost_full);
    almost_empty = (count <= th_almost_empty);
    rd_acc       = read && !fifo_empty;
    wr_acc       = write && (!fifo_full || read);
    overflow     = write && fifo_full && !read;
    underflow    = read && fifo_empty;
  end

  // Storage array is intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers wrap by natural overflow; count tracks net push/pop
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Sticky error: a new error wins over a coincident clear
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      fifo_error <= 1'b0;
    end else begin
      fifo_error <= (fifo_error && !err_clear) || overflow || underflow;
    end
  end

`ifdef FIFO_FWFT_EN
  // Head word shown directly; forced to zero while empty so reset clears the output
  always_comb begin
    valid         = !fifo_empty;
    fifo_data_out = fifo_empty ? '0 : mem[rd_ptr];
  end
`else
  // Registered pop: head captured on accepted read, held otherwise
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      fifo_data_out <= '0;
      valid         <= 1'b0;
    end else if (rd_acc) begin
      fifo_data_out <= mem[rd_ptr];
      valid         <= 1'b1;
    end else begin
      valid         <= 1'b0;
    end
  end
`endif

endmodule
